// File: rtl/core_mem_arbiter_pkg.sv
// Shared constants for the core memory-port arbiter.
// State encoding, owner codes and the default watchdog length.
package core_mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OWNER_INSTR = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/core_mem_arbiter_arb_rr2.sv
// Two-input round-robin grant function; purely combinational.
// A tie goes to the requester that did not win last time.
module arb_rr2
    import core_mem_arbiter_pkg::*;
(
    input  logic i_req_instr,
    input  logic i_req_data,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_grant
);

    assign o_valid = i_req_instr | i_req_data;

    always_comb begin
        o_grant = OWNER_INSTR;
        if (i_req_instr && i_req_data)
            o_grant = ~i_last_grant;
        else if (i_req_data)
            o_grant = OWNER_DATA;
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory-controller port between fetch and data requesters,
// with round-robin grants, held strobes and a hung-transaction watchdog.
module core_mem_arbiter
    import core_mem_arbiter_pkg::*;
#(
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_read,
    input  logic [BUS_WIDTH-1:0] instr_address,
    output logic [BUS_WIDTH-1:0] instr_read_data,
    output logic                 instr_response,
    input  logic                 data_read,
    input  logic                 data_write,
    input  logic [BUS_WIDTH-1:0] data_address,
    input  logic [BUS_WIDTH-1:0] data_write_data,
    output logic [BUS_WIDTH-1:0] data_read_data,
    output logic                 data_response,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [BUS_WIDTH-1:0] mem_address,
    output logic [BUS_WIDTH-1:0] mem_write_data,
    input  logic [BUS_WIDTH-1:0] mem_read_data,
    input  logic                 mem_response,
    output logic                 grant_owner,
    output logic                 timeout_error
);

    localparam logic [TIMEOUT_WIDTH-1:0] LP_WD_LAST =
        TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]               r_state;
    logic                     r_last_grant;
    logic                     r_grant_owner;
    logic                     r_is_write;
    logic                     r_mem_read;
    logic                     r_mem_write;
    logic [BUS_WIDTH-1:0]     r_addr;
    logic [BUS_WIDTH-1:0]     r_wdata;
    logic [BUS_WIDTH-1:0]     r_instr_rdata;
    logic [BUS_WIDTH-1:0]     r_data_rdata;
    logic                     r_instr_resp;
    logic                     r_data_resp;
    logic                     r_timeout;
    logic [TIMEOUT_WIDTH-1:0] r_wd;

    logic                 w_req_data;
    logic                 w_grant_valid;
    logic                 w_grant;
    logic                 w_wd_expired;
    logic                 w_finish;
    logic [BUS_WIDTH-1:0] w_cpl_data;

    assign w_req_data = data_read | data_write;

    arb_rr2 u_arb (
        .i_req_instr  (instr_read),
        .i_req_data   (w_req_data),
        .i_last_grant (r_last_grant),
        .o_valid      (w_grant_valid),
        .o_grant      (w_grant)
    );

    // A response arriving on the expiry cycle wins over the watchdog.
    assign w_wd_expired = (r_wd == LP_WD_LAST);
    assign w_finish     = mem_response | w_wd_expired;
    assign w_cpl_data   = (mem_response && !r_is_write) ?
                          mem_read_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= OWNER_DATA;
            r_grant_owner <= OWNER_INSTR;
            r_is_write    <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_instr_rdata <= '0;
            r_data_rdata  <= '0;
            r_instr_resp  <= 1'b0;
            r_data_resp   <= 1'b0;
            r_timeout     <= 1'b0;
            r_wd          <= '0;
        end else begin
            r_instr_resp <= 1'b0;
            r_data_resp  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_state       <= ST_BUSY;
                        r_grant_owner <= w_grant;
                        r_last_grant  <= w_grant;
                        r_wd          <= '0;
                        if (w_grant == OWNER_DATA) begin
                            r_addr      <= data_address;
                            r_wdata     <= data_write_data;
                            r_is_write  <= data_write;
                            r_mem_read  <= ~data_write;
                            r_mem_write <= data_write;
                        end else begin
                            r_addr      <= instr_address;
                            r_wdata     <= '0;
                            r_is_write  <= 1'b0;
                            r_mem_read  <= 1'b1;
                            r_mem_write <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_finish) begin
                        r_state     <= ST_DONE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        if (!mem_response)
                            r_timeout <= 1'b1;
                        if (r_grant_owner == OWNER_DATA) begin
                            r_data_resp  <= 1'b1;
                            r_data_rdata <= w_cpl_data;
                        end else begin
                            r_instr_resp  <= 1'b1;
                            r_instr_rdata <= w_cpl_data;
                        end
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign instr_read_data = r_instr_rdata;
    assign instr_response  = r_instr_resp;
    assign data_read_data  = r_data_rdata;
    assign data_response   = r_data_resp;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_address     = r_addr;
    assign mem_write_data  = r_wdata;
    assign grant_owner     = r_grant_owner;
    assign timeout_error   = r_timeout;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_core_mem_arbiter;

    localparam int BW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_read;
    logic [BW-1:0] instr_address;
    logic [BW-1:0] instr_read_data;
    logic          instr_response;
    logic          data_read;
    logic          data_write;
    logic [BW-1:0] data_address;
    logic [BW-1:0] data_write_data;
    logic [BW-1:0] data_read_data;
    logic          data_response;
    logic          mem_read;
    logic          mem_write;
    logic [BW-1:0] mem_address;
    logic [BW-1:0] mem_write_data;
    logic [BW-1:0] mem_read_data;
    logic          mem_response;
    logic          grant_owner;
    logic          timeout_error;

    core_mem_arbiter #(
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_WIDTH  (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_read      (instr_read),
        .instr_address   (instr_address),
        .instr_read_data (instr_read_data),
        .instr_response  (instr_response),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_address    (data_address),
        .data_write_data (data_write_data),
        .data_read_data  (data_read_data),
        .data_response   (data_response),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .mem_response    (mem_response),
        .grant_owner     (grant_owner),
        .timeout_error   (timeout_error)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Memory responder: answers in the mem_lat-th strobe cycle (0 = never)
    int            mem_lat = 0;
    int            cur_lat = 0;
    int            bcnt = 0;
    bit            rand_mem = 0;
    bit            stray_en = 0;
    bit            use_fixed = 0;
    logic [BW-1:0] fixed_data = '0;

    initial begin
        mem_response  = 1'b0;
        mem_read_data = '0;
        forever begin
            step();
            mem_read_data = use_fixed ? fixed_data : BW'($urandom);
            if (mem_read || mem_write) begin
                bcnt++;
                if (bcnt == 1)
                    cur_lat = rand_mem ? int'($urandom_range(1, 9)) : mem_lat;
                mem_response = (cur_lat != 0) && (bcnt == cur_lat);
            end else begin
                bcnt = 0;
                mem_response = stray_en && ($urandom_range(3) == 0);
            end
        end
    end

    // Reference model: one transaction at a time, tracked by its age
    bit            m_valid = 0;
    int            m_age = -1;
    bit            m_cool = 0;
    bit            m_own = 0;
    bit            m_wr = 0;
    bit            m_last = 1;
    bit            m_wi, m_wd, m_pick;
    logic [BW-1:0] m_v;
    logic          e_mr = 0, e_mw = 0, e_ir = 0, e_dr = 0;
    logic          e_go = 0, e_to = 0;
    logic [BW-1:0] e_ird = '0, e_drd = '0, e_addr = '0, e_wd = '0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_valid = 1; m_age = -1; m_cool = 0; m_last = 1;
            e_mr = 0; e_mw = 0; e_ir = 0; e_dr = 0; e_go = 0; e_to = 0;
            e_ird = '0; e_drd = '0; e_addr = '0; e_wd = '0;
        end else begin
            e_ir = 0;
            e_dr = 0;
            if (m_age >= 0) begin
                if (mem_response || m_age == TO - 1) begin
                    m_v = (mem_response && !m_wr) ? mem_read_data : '0;
                    if (m_own) begin e_dr = 1; e_drd = m_v; end
                    else begin e_ir = 1; e_ird = m_v; end
                    if (!mem_response) e_to = 1;
                    e_mr = 0; e_mw = 0;
                    m_age = -1; m_cool = 1;
                end else begin
                    m_age++;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else begin
                m_wi = instr_read;
                m_wd = data_read | data_write;
                if (m_wi || m_wd) begin
                    m_pick = (m_wi && m_wd) ? !m_last : m_wd;
                    m_last = m_pick; m_own = m_pick; e_go = m_pick;
                    m_age = 0;
                    m_wr = m_pick && data_write;
                    e_addr = m_pick ? data_address : instr_address;
                    e_wd = data_write_data;
                    e_mr = !m_wr; e_mw = m_wr;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("mem_read", mem_read, e_mr);
            chk("mem_write", mem_write, e_mw);
            chk("instr_response", instr_response, e_ir);
            chk("data_response", data_response, e_dr);
            chk("instr_read_data", instr_read_data, e_ird);
            chk("data_read_data", data_read_data, e_drd);
            chk("grant_owner", grant_owner, e_go);
            chk("timeout_error", timeout_error, e_to);
            if (e_mr || e_mw) chk("mem_address", mem_address, e_addr);
            if (e_mw) chk("mem_write_data", mem_write_data, e_wd);
            chk("one_resp", instr_response & data_response, 0);
            chk("one_strobe", mem_read & mem_write, 0);
        end
    end

    task automatic wait_resp(input bit who, output int sc,
                             output logic [BW-1:0] rd, output bit wr,
                             output bit rs, output int oth,
                             output logic [BW-1:0] fa,
                             output logic [BW-1:0] fw);
        bit got = 0;
        sc = 0; rd = '0; wr = 0; rs = 0; oth = 0; fa = '0; fw = '0;
        for (int k = 0; k < 40 && !got; k++) begin
            step();
            if ((mem_read || mem_write) && sc == 0) begin
                fa = mem_address;
                fw = mem_write_data;
            end
            if (mem_read || mem_write) sc++;
            wr |= mem_write;
            rs |= mem_read;
            if (who ? data_response : instr_response) begin
                got = 1;
                rd = who ? data_read_data : instr_read_data;
            end
            if (who ? instr_response : data_response) oth++;
        end
        chk("resp_seen", got, 1);
    endtask

    int            sc, oth, ng;
    bit            wr, rs, prev;
    logic [BW-1:0] rd, fa, fw;
    int            glog[4];

    initial begin
        reset = 1; instr_read = 0; data_read = 0; data_write = 0;
        instr_address = '0; data_address = '0; data_write_data = '0;
        repeat (3) step();
        chk("rst_ctl", {26'd0, mem_read, mem_write, instr_response,
                        data_response, grant_owner, timeout_error}, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_rdata", instr_read_data | data_read_data, 0);
        reset = 0;
        step();

        use_fixed = 1; fixed_data = 32'hDEADBEEF; mem_lat = 3;
        instr_address = 32'h100; instr_read = 1;
        wait_resp(0, sc, rd, wr, rs, oth, fa, fw);
        instr_read = 0;
        chk("fetch_strobes", sc, 3);
        chk("fetch_rdata", rd, 32'hDEADBEEF);
        chk("fetch_addr", fa, 32'h100);
        chk("fetch_other", oth, 0);
        chk("fetch_model", e_ird, 32'hDEADBEEF);
        step();

        mem_lat = 2; data_address = 32'h2000;
        data_write_data = 32'h12345678; data_write = 1;
        wait_resp(1, sc, rd, wr, rs, oth, fa, fw);
        data_write = 0;
        chk("store_write", wr, 1);
        chk("store_noread", rs, 0);
        chk("store_rdata", rd, 0);
        chk("store_addr", fa, 32'h2000);
        chk("store_wdata", fw, 32'h12345678);
        chk("store_strobes", sc, 2);
        step();

        reset = 1; step(); reset = 0;
        mem_lat = 1; instr_address = 32'h400; data_address = 32'h800;
        instr_read = 1; data_read = 1;
        ng = 0; prev = 0;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            step();
            if ((mem_read || mem_write) && !prev) begin
                glog[ng] = grant_owner;
                ng++;
            end
            prev = mem_read | mem_write;
            if (instr_response) instr_address += 4;
            if (data_response) data_address += 4;
        end
        instr_read = 0; data_read = 0;
        chk("cont_count", ng, 4);
        for (int i = 0; i < 4; i++) chk("cont_grant", glog[i], i % 2);
        repeat (4) step();

        stray_en = 1;
        repeat (6) begin
            step();
            chk("stray_idle", {30'd0, mem_read | mem_write,
                               instr_response | data_response}, 0);
        end
        stray_en = 0;

        mem_lat = 1; data_address = 32'h44; data_write_data = 32'hA5A5;
        data_read = 1; data_write = 1;
        wait_resp(1, sc, rd, wr, rs, oth, fa, fw);
        data_read = 0; data_write = 0;
        chk("rw_write", wr, 1);
        chk("rw_noread", rs, 0);
        step();

        fixed_data = 32'hCAFEF00D; mem_lat = TO;
        data_address = 32'h50; data_read = 1;
        wait_resp(1, sc, rd, wr, rs, oth, fa, fw);
        data_read = 0;
        chk("edge_strobes", sc, TO);
        chk("edge_rdata", rd, 32'hCAFEF00D);
        chk("edge_noerr", timeout_error, 0);
        step();

        mem_lat = 0; data_address = 32'h60; data_read = 1;
        wait_resp(1, sc, rd, wr, rs, oth, fa, fw);
        data_read = 0;
        chk("to_strobes", sc, TO);
        chk("to_rdata", rd, 0);
        chk("to_error", timeout_error, 1);
        chk("to_model", e_to, 1);
        step();
        mem_lat = 2; instr_address = 32'h70; instr_read = 1;
        wait_resp(0, sc, rd, wr, rs, oth, fa, fw);
        instr_read = 0;
        chk("to_after_rdata", rd, 32'hCAFEF00D);
        chk("to_sticky", timeout_error, 1);
        step();

        mem_lat = 0; instr_address = 32'h80; instr_read = 1;
        repeat (3) step();
        chk("mid_busy", mem_read, 1);
        reset = 1; instr_read = 0;
        step();
        chk("mid_rst_ctl", {26'd0, mem_read, mem_write, instr_response,
                            data_response, grant_owner, timeout_error}, 0);
        reset = 0;
        repeat (2) begin
            step();
            chk("mid_noresp", instr_response | data_response, 0);
        end
        mem_lat = 2; instr_address = 32'h90; data_address = 32'hA0;
        instr_read = 1; data_read = 1;
        step();
        chk("mid_tie_owner", grant_owner, 0);
        chk("mid_tie_addr", mem_address, 32'h90);
        wait_resp(0, sc, rd, wr, rs, oth, fa, fw);
        instr_read = 0;
        wait_resp(1, sc, rd, wr, rs, oth, fa, fw);
        data_read = 0;
        step();

        use_fixed = 0; rand_mem = 1; stray_en = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (instr_response) begin
                if ($urandom_range(1) == 1) instr_address = $urandom;
                else instr_read = 0;
            end else if (!instr_read && $urandom_range(3) == 0) begin
                instr_read = 1;
                instr_address = $urandom;
            end
            if (data_response || (!data_read && !data_write &&
                                  $urandom_range(3) == 0)) begin
                case ($urandom_range(3))
                    0: begin data_read = 1; data_write = 0; end
                    1: begin data_read = 0; data_write = 1; end
                    2: begin data_read = 1; data_write = 1; end
                    default: begin data_read = 0; data_write = 0; end
                endcase
                data_address = $urandom;
                data_write_data = $urandom;
            end
            reset = ($urandom_range(599) == 0);
        end
        reset = 0; instr_read = 0; data_read = 0; data_write = 0;
        stray_en = 0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
